// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage load enables, bubbles, load-use stalls, branch squash and dmem freeze.
// Pure control; a dmem access that outlives DMEM_TIMEOUT wait cycles parks the pipeline in ERR until reset.
module pipe_hazard_ctrl #(
   parameter int DMEM_TIMEOUT = 15,
   parameter int REG_W        = 5
) (
   input  logic             clk,
   input  logic             pc_rst,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic             e_memRead,
   input  logic [REG_W-1:0] e_writeReg,
   input  logic             e_branchTaken,
   input  logic             m_memRead,
   input  logic             m_memWrite,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             f_d_en,
   output logic             d_e_en,
   output logic             e_m_en,
   output logic             m_w_en,
   output logic             f_d_flush,
   output logic             d_e_flush,
   output logic             dmem_err,
   output logic [15:0]      stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_ERR      = 2'd2
   } state_t;

   localparam logic [7:0] LP_WAIT_LAST = 8'(DMEM_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_cnt_nxt;
   logic        r_dmem_err;
   logic        w_dmem_err_nxt;
   logic [15:0] r_stall_cnt;

   logic w_mem_access;
   logic w_load_use;
   logic w_req;
   logic w_busy;
   logic w_pc_en;
   logic w_f_d_en;
   logic w_d_e_en;
   logic w_e_m_en;
   logic w_m_w_en;
   logic w_f_d_flush;
   logic w_d_e_flush;

   assign w_mem_access = m_memRead | m_memWrite;

   // $0 is hardwired, so a load targeting it can never feed a dependent instruction.
   assign w_load_use = e_memRead & (e_writeReg != '0) &
                       ((e_writeReg == d_rs) | (e_writeReg == d_rt));

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_dmem_err_nxt = r_dmem_err;
      w_req          = 1'b0;
      w_busy         = 1'b0;
      w_pc_en        = 1'b0;
      w_f_d_en       = 1'b0;
      w_d_e_en       = 1'b0;
      w_e_m_en       = 1'b0;
      w_m_w_en       = 1'b0;
      w_f_d_flush    = 1'b0;
      w_d_e_flush    = 1'b0;

      case (r_state)
         S_RUN, S_MEM_WAIT: begin
            w_req  = w_mem_access;
            w_busy = w_req & ~dmem_ack;
            if (w_busy) begin
               if (r_state == S_RUN) begin
                  w_state_nxt = S_MEM_WAIT;
               end else if (r_wait_cnt == LP_WAIT_LAST) begin
                  w_state_nxt    = S_ERR;
                  w_dmem_err_nxt = 1'b1;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + 8'd1;
               end
            end else begin
               w_state_nxt    = S_RUN;
               w_wait_cnt_nxt = 8'd0;
               if (e_branchTaken) begin
                  // Squash IF and ID; the load-use check is moot for a squashed instruction.
                  w_pc_en     = 1'b1;
                  w_f_d_en    = 1'b1;
                  w_d_e_en    = 1'b1;
                  w_e_m_en    = 1'b1;
                  w_m_w_en    = 1'b1;
                  w_f_d_flush = 1'b1;
                  w_d_e_flush = 1'b1;
               end else if (w_load_use) begin
                  // Hold IF/ID for one cycle and push a bubble into EX.
                  w_d_e_en    = 1'b1;
                  w_e_m_en    = 1'b1;
                  w_m_w_en    = 1'b1;
                  w_d_e_flush = 1'b1;
               end else begin
                  w_pc_en  = 1'b1;
                  w_f_d_en = 1'b1;
                  w_d_e_en = 1'b1;
                  w_e_m_en = 1'b1;
                  w_m_w_en = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         r_state     <= S_RUN;
         r_wait_cnt  <= 8'd0;
         r_dmem_err  <= 1'b0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_dmem_err <= w_dmem_err_nxt;
         if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   // Reset gates every combinational control so nothing loads while reset is asserted.
   assign dmem_req  = pc_rst & w_req;
   assign pc_en     = pc_rst & w_pc_en;
   assign f_d_en    = pc_rst & w_f_d_en;
   assign d_e_en    = pc_rst & w_d_e_en;
   assign e_m_en    = pc_rst & w_e_m_en;
   assign m_w_en    = pc_rst & w_m_w_en;
   assign f_d_flush = pc_rst & w_f_d_flush;
   assign d_e_flush = pc_rst & w_d_e_flush;
   assign dmem_err  = r_dmem_err;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: rule-level model checked every cycle plus directed literal checks.
module tb_pipe_hazard_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        pc_rst = 1'b0;
   logic [4:0]  d_rs = '0, d_rt = '0, e_writeReg = '0;
   logic        e_memRead = 1'b0, e_branchTaken = 1'b0;
   logic        m_memRead = 1'b0, m_memWrite = 1'b0, dmem_ack = 1'b0;
   logic        dmem_req, pc_en, f_d_en, d_e_en, e_m_en, m_w_en;
   logic        f_d_flush, d_e_flush, dmem_err;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_fail = 0;

   pipe_hazard_ctrl #(.DMEM_TIMEOUT(T), .REG_W(5)) dut (
      .clk(clk), .pc_rst(pc_rst),
      .d_rs(d_rs), .d_rt(d_rt),
      .e_memRead(e_memRead), .e_writeReg(e_writeReg), .e_branchTaken(e_branchTaken),
      .m_memRead(m_memRead), .m_memWrite(m_memWrite), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .pc_en(pc_en), .f_d_en(f_d_en), .d_e_en(d_e_en),
      .e_m_en(e_m_en), .m_w_en(m_w_en), .f_d_flush(f_d_flush), .d_e_flush(d_e_flush),
      .dmem_err(dmem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: error latch, length of the current unbroken busy run, stall cycles.
   bit m_err;
   int m_streak;
   int m_stall;

   // {req, pc, fd, de, em, mw, fd_flush, de_flush}
   function automatic logic [7:0] f_exp();
      logic acc;
      logic lu;
      if (!pc_rst || m_err) return 8'b0;
      acc = m_memRead | m_memWrite;
      if (acc && !dmem_ack) return {acc, 7'b0};
      if (e_branchTaken) return {acc, 7'b1111111};
      lu = e_memRead && (e_writeReg != 5'd0) && (e_writeReg == d_rs || e_writeReg == d_rt);
      if (lu) return {acc, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      return {acc, 5'b11111, 2'b00};
   endfunction

   // A busy run of one RUN cycle plus T wait cycles is the error point.
   always @(posedge clk or negedge pc_rst) begin
      logic [7:0] e;
      if (!pc_rst) begin
         m_err = 1'b0;
         m_streak = 0;
         m_stall = 0;
      end else begin
         e = f_exp();
         if (!e[6] && m_stall < 65535) m_stall++;
         if (!m_err) begin
            if ((m_memRead || m_memWrite) && !dmem_ack) begin
               m_streak++;
               if (m_streak == T + 1) m_err = 1'b1;
            end else begin
               m_streak = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      e = f_exp();
      chk("dmem_req", dmem_req, e[7]);
      chk("pc_en", pc_en, e[6]);
      chk("f_d_en", f_d_en, e[5]);
      if (!e[0]) chk("d_e_en", d_e_en, e[4]);
      chk("e_m_en", e_m_en, e[3]);
      chk("m_w_en", m_w_en, e[2]);
      chk("f_d_flush", f_d_flush, e[1]);
      chk("d_e_flush", d_e_flush, e[0]);
      chk("dmem_err", dmem_err, m_err);
      chk("stall_cnt", stall_cnt, m_stall);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit rd, input bit wr, input bit ack, input bit br,
                        input bit emr, input logic [4:0] ewr, input logic [4:0] rs,
                        input logic [4:0] rt);
      m_memRead = rd; m_memWrite = wr; dmem_ack = ack; e_branchTaken = br;
      e_memRead = emr; e_writeReg = ewr; d_rs = rs; d_rt = rt;
      #2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic do_reset();
      pc_rst = 1'b0;
      idle();
      cyc(); cyc();
      pc_rst = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_stall", stall_cnt, 0);
      chk("rst_err", dmem_err, 0);

      // Normal flow
      idle();
      chk("norm_pc", pc_en, 1);
      cyc();

      // Single-cycle dmem access: no stall
      drive(1, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
      chk("1cyc_req", dmem_req, 1);
      chk("1cyc_pc", pc_en, 1);
      cyc();
      idle();
      chk("1cyc_stall", stall_cnt, 0);
      cyc();

      // Three-cycle write
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      chk("3cyc_pc0", pc_en, 0);
      cyc();
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      chk("3cyc_pc1", pc_en, 0);
      cyc();
      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      chk("3cyc_pc2", pc_en, 1);
      chk("3cyc_mw2", m_w_en, 1);
      cyc();
      idle();
      chk("3cyc_stall", stall_cnt, 2);
      cyc();

      // Load-use on rt, then same with $0 destination
      drive(0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5);
      chk("lu_pc", pc_en, 0);
      chk("lu_fd", f_d_en, 0);
      chk("lu_def", d_e_flush, 1);
      chk("lu_mw", m_w_en, 1);
      cyc();
      idle();
      chk("lu_stall", stall_cnt, 3);
      cyc();
      drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      chk("lu0_pc", pc_en, 1);
      chk("lu0_def", d_e_flush, 0);
      cyc();

      // Branch beats load-use; memory freeze beats branch
      drive(0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd1);
      chk("br_pc", pc_en, 1);
      chk("br_fdf", f_d_flush, 1);
      chk("br_def", d_e_flush, 1);
      cyc();
      drive(1, 0, 0, 1, 1, 5'd7, 5'd7, 5'd1);
      chk("frz_pc", pc_en, 0);
      chk("frz_fdf", f_d_flush, 0);
      chk("frz_def", d_e_flush, 0);
      cyc();
      drive(1, 0, 1, 1, 1, 5'd7, 5'd7, 5'd1);
      chk("frz_ack_pc", pc_en, 1);
      chk("frz_ack_fdf", f_d_flush, 1);
      cyc();
      idle();
      chk("br_stall", stall_cnt, 4);
      cyc();

      // Asynchronous reset while waiting on dmem
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc();
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      pc_rst = 1'b0;
      #1;
      chk("arst_req", dmem_req, 0);
      chk("arst_pc", pc_en, 0);
      chk("arst_mw", m_w_en, 0);
      chk("arst_stall", stall_cnt, 0);
      cyc();
      idle();
      pc_rst = 1'b1;
      #1;
      chk("arst_run_pc", pc_en, 1);
      chk("arst_err", dmem_err, 0);
      cyc();
      chk("arst_stall2", stall_cnt, 0);

      // Timeout into ERR
      do_reset();
      for (int i = 0; i < T + 1; i++) begin
         drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
         if (i < T) chk("to_err_pre", dmem_err, 0);
         cyc();
      end
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      chk("to_err", dmem_err, 1);
      chk("to_req", dmem_req, 0);
      chk("to_pc", pc_en, 0);
      chk("to_stall", stall_cnt, T + 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
         chk("to_ack_pc", pc_en, 0);
         chk("to_ack_mw", m_w_en, 0);
         cyc();
      end
      idle();
      chk("to_stall2", stall_cnt, T + 4);
      chk("to_err2", dmem_err, 1);
      do_reset();
      idle();
      chk("to_rst_err", dmem_err, 0);
      chk("to_rst_pc", pc_en, 1);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
